// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 set-2 keyboard event decoder.
package kbd_pkg;

  // Prefix bytes that may appear in key_code[23:8].
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Modifier and lock key codes (code byte only; E0 variants share the byte).
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  // One queued event; also used for the decode stage, where data holds the raw code.
  typedef struct packed {
    logic [7:0] data;
    logic       make;
    logic       ext;
  } kbd_event_t;

  typedef enum logic [2:0] {
    KEY_OTHER,
    KEY_LSHIFT,
    KEY_RSHIFT,
    KEY_CTRL,
    KEY_ALT,
    KEY_CAPS
  } key_class_t;

  // Sort a code byte into modifier / lock / ordinary key.
  function automatic key_class_t classify_key(input logic [7:0] code);
    case (code)
      CODE_LSHIFT: return KEY_LSHIFT;
      CODE_RSHIFT: return KEY_RSHIFT;
      CODE_CTRL:   return KEY_CTRL;
      CODE_ALT:    return KEY_ALT;
      CODE_CAPS:   return KEY_CAPS;
      default:     return KEY_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/kbd_ascii_rom.sv
// Set-2 scan code to ASCII table; only instantiated when KBD_ASCII_EN is defined.
// Letters follow shift XOR caps; digits follow shift only; unmapped codes give 0x00.
module kbd_ascii_rom (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic [7:0] plain;
  logic [7:0] shifted;

  // Look the code up in the letter and symbol tables, then apply shift/caps.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    lower   = 8'h00;
    plain   = 8'h00;
    shifted = 8'h00;
    case (code)
      8'h1C: lower = 8'h61; 8'h32: lower = 8'h62; 8'h21: lower = 8'h63;
      8'h23: lower = 8'h64; 8'h24: lower = 8'h65; 8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67; 8'h33: lower = 8'h68; 8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A; 8'h42: lower = 8'h6B; 8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D; 8'h31: lower = 8'h6E; 8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70; 8'h15: lower = 8'h71; 8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73; 8'h2C: lower = 8'h74; 8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76; 8'h1D: lower = 8'h77; 8'h22: lower = 8'h78;
      8'h35: lower = 8'h79; 8'h1A: lower = 8'h7A;
      default: lower = 8'h00;
    endcase
    case (code)
      8'h45: begin plain = 8'h30; shifted = 8'h29; end
      8'h16: begin plain = 8'h31; shifted = 8'h21; end
      8'h1E: begin plain = 8'h32; shifted = 8'h40; end
      8'h26: begin plain = 8'h33; shifted = 8'h23; end
      8'h25: begin plain = 8'h34; shifted = 8'h24; end
      8'h2E: begin plain = 8'h35; shifted = 8'h25; end
      8'h36: begin plain = 8'h36; shifted = 8'h5E; end
      8'h3D: begin plain = 8'h37; shifted = 8'h26; end
      8'h3E: begin plain = 8'h38; shifted = 8'h2A; end
      8'h46: begin plain = 8'h39; shifted = 8'h28; end
      8'h29: begin plain = 8'h20; shifted = 8'h20; end
      8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
      8'h66: begin plain = 8'h08; shifted = 8'h08; end
      default: ;
    endcase
    if (lower != 8'h00) ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
    else                ascii = shift ? shifted : plain;
  end

endmodule

// File: rtl/kbd_event_decoder.sv
// PS/2 set-2 key event decoder: new-code detect, decode stage, modifier
// tracking and an event FIFO. Define KBD_ASCII_EN to translate codes to
// ASCII; otherwise ev_data carries the raw code byte.
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [23:0]                 key_code,
  input  logic                        parity_error,
  input  logic                        frame_error,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_data,
  output logic                        ev_make,
  output logic                        ev_ext,
  output logic [3:0]                  modifiers,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        err_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [23:0] prev_code;
  logic        new_code;
  logic        code_err;
  logic        dec_valid;
  kbd_event_t  dec;
  key_class_t  dec_class;
  logic        lshift, rshift, ctrl, alt, caps_lock;
  logic [7:0]  ev_byte;
  logic        push, pop, full, wr_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  kbd_event_t    mem [FIFO_DEPTH];
  kbd_event_t    head;

  assign new_code = (key_code != prev_code) && (key_code != 24'h0);
  assign code_err = parity_error | frame_error;

  // Detect stage: remember last code, latch clean new codes, flag corrupted ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      prev_code <= 24'h0;
      dec_valid <= 1'b0;
      dec       <= '0;
      err_seen  <= 1'b0;
    end else begin
      prev_code <= key_code;
      dec_valid <= new_code && !code_err;
      if (new_code && !code_err) begin
        dec.data <= key_code[7:0];
        dec.make <= !((key_code[23:16] == PFX_BRK) || (key_code[15:8] == PFX_BRK));
        dec.ext  <= (key_code[23:16] == PFX_EXT) || (key_code[15:8] == PFX_EXT);
      end
      if (new_code && code_err) err_seen <= 1'b1;
    end
  end

  assign dec_class = classify_key(dec.data);
  assign push      = dec_valid && (dec_class == KEY_OTHER);

  // Modifier state: make sets, break clears; caps toggles on make only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      ctrl      <= 1'b0;
      alt       <= 1'b0;
      caps_lock <= 1'b0;
    end else if (dec_valid) begin
      case (dec_class)
        KEY_LSHIFT: lshift <= dec.make;
        KEY_RSHIFT: rshift <= dec.make;
        KEY_CTRL:   ctrl   <= dec.make;
        KEY_ALT:    alt    <= dec.make;
        KEY_CAPS:   if (dec.make) caps_lock <= ~caps_lock;
        default: ;
      endcase
    end
  end

  assign modifiers = {alt, ctrl, lshift | rshift, caps_lock};

`ifdef KBD_ASCII_EN
  kbd_ascii_rom u_ascii_rom (
    .code  (dec.data),
    .shift (lshift | rshift),
    .caps  (caps_lock),
    .ascii (ev_byte)
  );
`else
  assign ev_byte = dec.data;
`endif

  assign full  = (count == DEPTH_CNT);
  assign pop   = ev_valid && ev_ready;
  assign wr_en = push && (!full || pop);

  // Event storage: written in order at wr_ptr, read at rd_ptr.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; count gates every read so stale contents are never visible.
    if (wr_en) mem[wr_ptr] <= '{data: ev_byte, make: dec.make, ext: dec.ext};
  end

  // FIFO pointers, occupancy and sticky overflow; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_valid   = (count != '0);
  assign ev_data    = ev_valid ? head.data : 8'h00;
  assign ev_make    = ev_valid ? head.make : 1'b0;
  assign ev_ext     = ev_valid ? head.ext  : 1'b0;
  assign fifo_count = count;

endmodule

// File: doc/kbd_event_decoder.md
KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth in entries; power of two, minimum 2.
REQ-002 Port clk, input, 1, single system clock; all state on rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous, active-high.
REQ-004 Port key_code, input, 24, PS/2 set-2 code from upstream receiver, format {prefix2, prefix1, code}, held until next valid code.
REQ-005 Port parity_error, input, 1, upstream parity error flag.
REQ-006 Port frame_error, input, 1, upstream frame error flag.
REQ-007 Port ev_valid, output, 1, FIFO head event available.
REQ-008 Port ev_ready, input, 1, consumer accepts head event.
REQ-009 Port ev_data, output, 8, ASCII or raw scan byte of head event.
REQ-010 Port ev_make, output, 1, head event is make (1) or break (0).
REQ-011 Port ev_ext, output, 1, head event carried E0 prefix.
REQ-012 Port modifiers, output, 4, {alt, ctrl, shift, caps_lock} current state.
REQ-013 Port fifo_count, output, $clog2(FIFO_DEPTH)+1, occupied entries.
REQ-014 Port overflow, output, 1, sticky, event dropped on full FIFO.
REQ-015 Port err_seen, output, 1, sticky, code change observed while an error flag was high.

Function
REQ-016 SHALL register previous key_code (prev_code); new code = key_code != prev_code and key_code != 0; prev_code updates every cycle.
REQ-017 New code seen while parity_error or frame_error high SHALL be dropped and SHALL set err_seen.
REQ-018 Repeated identical codes (typematic) SHALL produce no event.
REQ-019 Break = any prefix byte == F0; extended = any prefix byte == E0.
REQ-020 Pipeline: detect in cycle N, decode register at edge N+1, FIFO write at edge N+2; ev_valid high after edge N+2 when FIFO was empty.
REQ-021 Modifier codes (shift 12/59, ctrl 14 and E0 14, alt 11 and E0 11) SHALL update modifiers (make sets, break clears; shift = L OR R) and SHALL NOT enter FIFO.
REQ-022 Code 58 make SHALL toggle caps_lock; its break SHALL be ignored; neither enters FIFO.
REQ-023 All other codes, make and break, SHALL be pushed as {ev_data, ev_make, ev_ext}.
REQ-024 Pop SHALL occur on edge where ev_valid and ev_ready both high.
REQ-025 Push on full FIFO without simultaneous pop SHALL be dropped and set overflow; push with pop on full SHALL succeed.
REQ-026 Push and ready on empty FIFO in same cycle: push succeeds, no pop.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; ordering strictly FIFO.

Reset
REQ-028 rst SHALL asynchronously clear prev_code, pipeline, FIFO, modifiers, overflow, err_seen; ev_valid=0, ev_data=0, ev_make=0, ev_ext=0, fifo_count=0.
REQ-029 A decode in flight at reset SHALL be discarded; key_code held after release SHALL be treated as new if nonzero.

Configuration
REQ-030 Macro KBD_ASCII_EN defined: ev_data = ASCII of code (letters, digits, space 0x20, enter 0x0D, backspace 0x08); letters upper when shift XOR caps_lock; digits/punctuation shifted by shift only; unmapped = 0x00, still pushed.
REQ-031 Macro KBD_ASCII_EN undefined: ev_data = raw code byte key_code[7:0]; no ASCII table synthesised; modifiers still tracked.

Structure
REQ-032 Package kbd_pkg SHALL hold prefix constants (E0, F0), modifier/caps code constants, event struct typedef.
REQ-033 Sub-module kbd_ascii_rom (code, shift, caps -> ascii) SHALL exist, instantiated only under KBD_ASCII_EN.

Verification
REQ-034 key_code 00001C, ASCII on -> one event ev_data=0x61, ev_make=1, ev_ext=0, ev_valid after 2 edges.
REQ-035 000012, then 00001C, then 00F012 -> shift set, event 0x41, shift cleared; 12 never in FIFO.
REQ-036 000058, 00F058, then 000012, 000016 -> caps_lock=1, event 0x21 (caps ignored for digits).
REQ-037 ev_ready=0, 9 distinct non-modifier codes, FIFO_DEPTH=8 -> fifo_count=8, overflow=1, reads return first 8 in order.
REQ-038 parity_error=1 while key_code changes to 00001C -> no event, err_seen=1; 00E075 after clear -> ev_ext=1, ev_make=1.
REQ-039 rst asserted with 3 entries queued -> ev_valid=0 and fifo_count=0 immediately, before next clk edge.
